// File: rtl/bram_pkg.sv
// Shared definitions for the simple-dual-port byte-enabled BRAM family.
package bram_pkg;

    // Same-word read/write collision policy.
    typedef enum logic {
        READ_FIRST  = 1'b0,
        WRITE_FIRST = 1'b1
    } rd_mode_e;

    localparam int unsigned BYTE_W = 8;

endpackage

// File: rtl/bram_sdp_array.sv
// Raw block-RAM storage: one byte-enabled write port, one enabled synchronous
// read port. No reset; contents are retained across rst.
module bram_sdp_array
    import bram_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4096
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_idx,
    input  logic [XLEN-1:0]          wr_data,
    input  logic [XLEN/8-1:0]        wr_be,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic [XLEN-1:0]          rd_q
);

    localparam int unsigned NB = XLEN / 8;

    (* ram_style = "block" *) logic [XLEN-1:0] mem [DEPTH];

    // Byte-lane writes and read-before-write registered read.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NB; i++) begin
            if (wr_en && wr_be[i]) begin
                mem[wr_idx][i*BYTE_W +: BYTE_W] <= wr_data[i*BYTE_W +: BYTE_W];
            end
        end
        if (rd_en) begin
            rd_q <= mem[rd_idx];
        end
    end

endmodule

// File: rtl/bram_sdp_byte_pipe.sv
// Simple-dual-port byte-enabled BRAM wrapper with collision handling,
// consumer back-pressure (rd_hold) and a 1- or 2-cycle read pipeline.
module bram_sdp_byte_pipe
    import bram_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned DEPTH      = 4096,
    parameter int unsigned RD_LATENCY = 1,
    parameter rd_mode_e    RD_MODE    = READ_FIRST,
    localparam int unsigned NB        = XLEN / 8,
    localparam int unsigned AW        = $clog2(DEPTH) + $clog2(NB)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic [NB-1:0]   wr_be,
    input  logic            rd_en,
    input  logic [AW-1:0]   rd_addr,
    input  logic            rd_hold,
    output logic            rd_ready,
    output logic [XLEN-1:0] rd_data,
    output logic            rd_valid
);

    localparam int unsigned OFS = $clog2(NB);
    localparam int unsigned WW  = $clog2(DEPTH);

    logic [WW-1:0]   wr_idx;
    logic [WW-1:0]   rd_idx;
    logic            rd_accept;
    logic [XLEN-1:0] arr_q;

    // Stage 1: array output plus forwarded write bytes captured at accept.
    logic            s1_valid;
    logic [NB-1:0]   s1_fwd_be;
    logic [XLEN-1:0] s1_fwd_data;
    logic [XLEN-1:0] s1_data;

    assign wr_idx = wr_addr[AW-1:OFS];
    assign rd_idx = rd_addr[AW-1:OFS];

    // Byte offset bits carry no meaning: all accesses are word-aligned.
    logic unused_addr_lsbs;
    if (OFS > 0) begin : g_lsbs
        assign unused_addr_lsbs = ^{wr_addr[OFS-1:0], rd_addr[OFS-1:0]};
    end else begin : g_no_lsbs
        assign unused_addr_lsbs = 1'b0;
    end

    assign rd_ready  = ~rd_hold;
    // A read presented while rst is high is dropped.
    assign rd_accept = rd_en & rd_ready & ~rst;

    bram_sdp_array #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_array (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_data (wr_data),
        .wr_be   (wr_be),
        .rd_en   (rd_accept),
        .rd_idx  (rd_idx),
        .rd_q    (arr_q)
    );

    // Stage-1 valid and collision-forwarding capture; frozen while held.
    // The array is read-first, so write-first is obtained by overlaying the
    // same-cycle write bytes on the array word one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s1_fwd_be   <= '0;
            s1_fwd_data <= '0;
        end else if (!rd_hold) begin
            s1_valid    <= rd_accept;
            s1_fwd_data <= wr_data;
            if (RD_MODE == WRITE_FIRST && wr_en && wr_idx == rd_idx) begin
                s1_fwd_be <= wr_be;
            end else begin
                s1_fwd_be <= '0;
            end
        end
    end

    // Per-lane merge of forwarded write bytes over the array word.
    always_comb begin
        s1_data = arr_q;
        for (int unsigned i = 0; i < NB; i++) begin
            if (s1_fwd_be[i]) begin
                s1_data[i*BYTE_W +: BYTE_W] = s1_fwd_data[i*BYTE_W +: BYTE_W];
            end
        end
    end

    if (RD_LATENCY == 2) begin : g_lat2
        logic            s2_valid;
        logic [XLEN-1:0] s2_data;

        // Second output register stage, frozen while held.
        always_ff @(posedge clk) begin
            if (rst) begin
                s2_valid <= 1'b0;
                s2_data  <= '0;
            end else if (!rd_hold) begin
                s2_valid <= s1_valid;
                s2_data  <= s1_valid ? s1_data : '0;
            end
        end

        assign rd_valid = s2_valid;
        assign rd_data  = s2_data;
    end else begin : g_lat1
        // Array register is not reset, so gate it to give zero data when idle.
        assign rd_valid = s1_valid;
        assign rd_data  = s1_valid ? s1_data : '0;
    end

endmodule

// File: tb/tb_bram_sdp_byte_pipe.sv
// Bench for bram_sdp_byte_pipe: four instances (latency 1/2 x read-first /
// write-first) share one stimulus stream and are compared every cycle against
// a read-log model, plus directed literal expectations.
module tb_bram_sdp_byte_pipe;
    import bram_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        rd_en;
    logic [7:0]  rd_addr;
    logic        rd_hold;

    logic [3:0]  rdy;
    logic [3:0]  vld;
    logic [31:0] dat [4];

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Model: word memory, count of advancing edges, and read results keyed by
    // the edge count at which each read was accepted.
    logic [31:0] mem_m [64];
    int          tick = 0;
    logic [31:0] m_rf [int];
    logic [31:0] m_wf [int];
    int          m_ri;
    int          m_wi;
    logic [31:0] m_old;
    logic [31:0] m_fwd;

    logic [31:0] exp_seq [8];
    logic [31:0] got0 [$];
    logic [31:0] got1 [$];

    always #5 clk = ~clk;

    bram_sdp_byte_pipe #(.XLEN(32), .DEPTH(64), .RD_LATENCY(1), .RD_MODE(READ_FIRST)) u0 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_hold(rd_hold),
        .rd_ready(rdy[0]), .rd_data(dat[0]), .rd_valid(vld[0]));
    bram_sdp_byte_pipe #(.XLEN(32), .DEPTH(64), .RD_LATENCY(2), .RD_MODE(READ_FIRST)) u1 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_hold(rd_hold),
        .rd_ready(rdy[1]), .rd_data(dat[1]), .rd_valid(vld[1]));
    bram_sdp_byte_pipe #(.XLEN(32), .DEPTH(64), .RD_LATENCY(1), .RD_MODE(WRITE_FIRST)) u2 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_hold(rd_hold),
        .rd_ready(rdy[2]), .rd_data(dat[2]), .rd_valid(vld[2]));
    bram_sdp_byte_pipe #(.XLEN(32), .DEPTH(64), .RD_LATENCY(2), .RD_MODE(WRITE_FIRST)) u3 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_hold(rd_hold),
        .rd_ready(rdy[3]), .rd_data(dat[3]), .rd_valid(vld[3]));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: actual=%08h required=%08h", nm, act, expv);
        end
    endtask

    // Apply one cycle of inputs; returns 1ns after the edge that sampled them.
    task automatic cyc(input bit r, input bit we, input logic [7:0] wa, input logic [31:0] wd,
                       input logic [3:0] wbe, input bit re, input logic [7:0] ra, input bit h);
        rst = r; wr_en = we; wr_addr = wa; wr_data = wd; wr_be = wbe;
        rd_en = re; rd_addr = ra; rd_hold = h;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 8'h00, 32'h0, 4'h0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        cyc(1'b0, 1'b1, a, d, be, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic rd(input logic [7:0] a);
        cyc(1'b0, 1'b0, 8'h00, 32'h0, 4'h0, 1'b1, a, 1'b0);
    endtask

    // Model update from the rules: reads see the word before any same-edge
    // write (write-first overlays the written lanes); rst drops everything.
    always @(posedge clk) begin
        m_ri = int'(rd_addr[7:2]);
        m_wi = int'(wr_addr[7:2]);
        if (rst) begin
            m_rf.delete();
            m_wf.delete();
            tick++;
        end else if (!rd_hold) begin
            tick++;
            if (rd_en) begin
                m_old = mem_m[m_ri];
                m_fwd = m_old;
                if (wr_en && m_wi == m_ri) begin
                    for (int b = 0; b < 4; b++) begin
                        if (wr_be[b]) m_fwd[b*8 +: 8] = wr_data[b*8 +: 8];
                    end
                end
                m_rf[tick] = m_old;
                m_wf[tick] = m_fwd;
            end
        end
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) mem_m[m_wi][b*8 +: 8] = wr_data[b*8 +: 8];
            end
        end
    end

    // Every-cycle comparison of all instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 4; i++) begin
                automatic int   lat = (i % 2 == 0) ? 1 : 2;
                automatic bit   wf  = (i >= 2);
                automatic int   key = tick - (lat - 1);
                automatic bit   ev;
                automatic logic [31:0] ed;
                ev = wf ? (m_wf.exists(key) != 0) : (m_rf.exists(key) != 0);
                chk($sformatf("u%0d rd_ready", i), {31'b0, rdy[i]}, {31'b0, ~rd_hold});
                chk($sformatf("u%0d rd_valid", i), {31'b0, vld[i]}, {31'b0, ev});
                if (ev) begin
                    ed = wf ? m_wf[key] : m_rf[key];
                    chk($sformatf("u%0d rd_data", i), dat[i], ed);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        cyc(1'b1, 1'b0, 8'h00, 32'h0, 4'h0, 1'b0, 8'h00, 1'b0);
        chk_en = 1'b1;
        cyc(1'b1, 1'b0, 8'h00, 32'h0, 4'h0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("reset u%0d valid", i), {31'b0, vld[i]}, 32'h0);
            chk($sformatf("reset u%0d data", i), dat[i], 32'h0);
        end
        idle(1);

        // Fill words 0..15
        for (int i = 0; i < 16; i++) wr(8'(i * 4), 32'hC0DE_0000 + 32'(i), 4'hF);

        // Full-word write and read latency
        wr(8'h10, 32'hDEAD_BEEF, 4'hF);
        rd(8'h10);
        chk("lat1 valid", {31'b0, vld[0]}, 32'h1);
        chk("lat1 data", dat[0], 32'hDEAD_BEEF);
        chk("lat2 early", {31'b0, vld[1]}, 32'h0);
        idle(1);
        chk("lat2 valid", {31'b0, vld[1]}, 32'h1);
        chk("lat2 data", dat[1], 32'hDEAD_BEEF);
        chk("lat1 drop", {31'b0, vld[0]}, 32'h0);
        idle(1);

        // Partial byte enables
        wr(8'h20, 32'h1122_3344, 4'hF);
        wr(8'h20, 32'hAABB_CCDD, 4'b0101);
        rd(8'h20);
        chk("be0101 lat1", dat[0], 32'h11BB_33DD);
        idle(1);
        chk("be0101 lat2", dat[1], 32'h11BB_33DD);
        idle(1);

        // Same-cycle collision
        wr(8'h30, 32'h0, 4'hF);
        cyc(1'b0, 1'b1, 8'h30, 32'hFFFF_FFFF, 4'b0011, 1'b1, 8'h30, 1'b0);
        chk("coll rf lat1", dat[0], 32'h0000_0000);
        chk("coll wf lat1", dat[2], 32'h0000_FFFF);
        idle(1);
        chk("coll rf lat2", dat[1], 32'h0000_0000);
        chk("coll wf lat2", dat[3], 32'h0000_FFFF);
        rd(8'h30);
        chk("after coll rf", dat[0], 32'h0000_FFFF);
        idle(2);

        // Back-to-back stream with a 3-cycle hold; word 3 rewritten mid-hold
        for (int i = 0; i < 8; i++) exp_seq[i] = 32'hC0DE_0000 + 32'(i);
        exp_seq[4] = 32'hDEAD_BEEF;
        for (int s = 0; s < 13; s++) begin
            automatic bit h = (s >= 4 && s <= 6);
            if (s < 4)
                rd(8'(s * 4));
            else if (h)
                cyc(1'b0, (s == 5), 8'h0C, 32'h3333_CCCC, 4'hF, 1'b1, 8'h10, 1'b1);
            else if (s < 11)
                rd(8'((s - 3) * 4));
            else
                idle(1);
            if (h) begin
                chk("hold u0 valid", {31'b0, vld[0]}, 32'h1);
                chk("hold u0 data", dat[0], exp_seq[3]);
                chk("hold u1 valid", {31'b0, vld[1]}, 32'h1);
                chk("hold u1 data", dat[1], exp_seq[2]);
            end else begin
                if (vld[0]) got0.push_back(dat[0]);
                if (vld[1]) got1.push_back(dat[1]);
            end
        end
        chk("stream u0 count", 32'(got0.size()), 32'd8);
        chk("stream u1 count", 32'(got1.size()), 32'd8);
        for (int k = 0; k < 8; k++) begin
            if (k < got0.size()) chk($sformatf("stream u0 [%0d]", k), got0[k], exp_seq[k]);
            if (k < got1.size()) chk($sformatf("stream u1 [%0d]", k), got1[k], exp_seq[k]);
        end
        idle(1);

        // Reset with reads in flight; write during rst still lands
        rd(8'h04);
        rd(8'h08);
        cyc(1'b1, 1'b1, 8'h24, 32'h9999_9999, 4'hF, 1'b1, 8'h0C, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("midrst u%0d valid", i), {31'b0, vld[i]}, 32'h0);
            chk($sformatf("midrst u%0d data", i), dat[i], 32'h0);
        end
        idle(1);
        chk("postrst u1 valid", {31'b0, vld[1]}, 32'h0);
        rd(8'h24);
        chk("rst-cycle write", dat[0], 32'h9999_9999);
        rd(8'h0C);
        chk("held-word rewrite", dat[0], 32'h3333_CCCC);
        rd(8'h1C);
        chk("retained word7", dat[0], 32'hC0DE_0007);
        idle(3);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bram_sdp_byte_pipe.md
BRAM_SDP_BYTE_PIPE -- requirements
Module: bram_sdp_byte_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32: data width in bits, a multiple of 8.
REQ-002 SHALL have parameter DEPTH, default 4096: number of XLEN-bit words, a power of two.
REQ-003 SHALL have parameter RD_LATENCY, default 1: read latency in cycles, legal values 1 or 2.
REQ-004 SHALL have parameter RD_MODE, default READ_FIRST: same-word collision policy, READ_FIRST or WRITE_FIRST.
REQ-005 SHALL derive NB = XLEN/8 (byte lanes) and AW = $clog2(DEPTH)+$clog2(NB) (byte-address width) as localparams.
REQ-006 SHALL have the ports below, clock and reset first:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write request.
- wr_addr  in  AW  write byte address.
- wr_data  in  XLEN  write data.
- wr_be  in  NB  per-byte write enable.
- rd_en  in  1  read request.
- rd_addr  in  AW  read byte address.
- rd_hold  in  1  consumer stall.
- rd_ready  out  1  read request accepted this cycle.
- rd_data  out  XLEN  read data.
- rd_valid  out  1  rd_data is valid.

Function
REQ-007 SHALL form the word index as addr[AW-1:$clog2(NB)] and SHALL ignore the low address bits; there are no misaligned accesses.
REQ-008 SHALL write byte lane i of the indexed word when wr_en & wr_be[i], with the update visible in the array at the next posedge.
REQ-009 SHALL ignore a write with wr_be == 0, and SHALL accept writes regardless of rd_hold.
REQ-010 SHALL drive rd_ready = ~rd_hold combinationally, and SHALL accept a read only when rd_en & rd_ready.
REQ-011 SHALL, with RD_LATENCY=1, present the data of a read accepted at edge N and assert rd_valid after edge N+1.
REQ-012 SHALL, with RD_LATENCY=2, register the output once more so the data appears after edge N+2.
REQ-013 SHALL freeze every pipeline stage, rd_data and rd_valid while rd_hold=1, so no read is lost or duplicated.
REQ-014 SHALL deassert rd_valid for exactly the cycles in which no accepted read reaches the output.
REQ-015 SHALL sustain one accepted read per cycle back-to-back, with no bubbles when rd_hold=0.
REQ-016 SHALL, on a same-cycle write and read to the same word with RD_MODE=READ_FIRST, return the pre-write word.
REQ-017 SHALL, on a same-cycle write and read to the same word with RD_MODE=WRITE_FIRST, forward new bytes on lanes with wr_be[i]=1 and old bytes on the other lanes.
REQ-018 SHALL make a write in any earlier cycle visible to a later read in both modes, including a write that occurs while a read of the same word is held in the pipeline.
REQ-019 SHALL treat a read accepted in the same cycle that rst is asserted as discarded.

Reset
REQ-020 SHALL, on rst, clear rd_valid, rd_data and all pipeline valid and data registers to 0 at the next posedge.
REQ-021 SHALL NOT reset or clear the memory array; its contents after reset are retained and undefined at power-up.
REQ-022 SHALL, when rst is asserted mid-read, produce no rd_valid for reads in flight; writes in the rst cycle are still performed.

Structure
REQ-023 SHALL take enum rd_mode_e {READ_FIRST, WRITE_FIRST} from shared package bram_pkg.
REQ-024 SHALL place the storage in sub-module bram_sdp_array: no reset, ram_style block, one byte-enabled write port and one enabled synchronous read port.
REQ-025 SHALL keep the collision compare, forwarding mux, hold logic and output pipeline in bram_sdp_byte_pipe.

Verification
REQ-026 SHALL cover: write 0xDEADBEEF to addr 0x10 with be=1111, then read 0x10 -> rd_data=0xDEADBEEF, valid 1 cycle after accept (LAT=1) and 2 cycles after (LAT=2).
REQ-027 SHALL cover: word 0x11223344 at 0x20, write 0xAABBCCDD with be=0101 -> read returns 0x11BB33DD.
REQ-028 SHALL cover: word 0x0 at 0x30, same-cycle write 0xFFFFFFFF be=0011 and read 0x30 -> READ_FIRST returns 0x00000000; WRITE_FIRST returns 0x0000FFFF.
REQ-029 SHALL cover: 8 back-to-back reads of addrs 0x00..0x1C with rd_hold pulsed 3 cycles mid-stream -> 8 valid results in order, none dropped or duplicated, rd_data stable during hold.
REQ-030 SHALL cover: rst asserted with 2 reads in flight -> rd_valid=0 and rd_data=0 next cycle; memory contents preserved on a read after reset.
